// File: rtl/reg_bank_loader.sv
// reg_bank_loader: four-entry 8-bit register bank loaded over a 4-bit nibble
// stream. The command nibble is {op[1:0], addr[1:0]}. The supported ops are
// WRITE (two data nibbles), CLEAR, INC and SEL. A partial command is aborted
// once the stream has been idle for TIMEOUT cycles in the middle of it.
module reg_bank_loader #(
    parameter logic [7:0]  RESET_VAL = 8'h00,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] nibIn,
    input  logic       nibValid,
    output logic       nibReady,
    output logic [7:0] regOut0,
    output logic [7:0] regOut1,
    output logic [7:0] regOut2,
    output logic [7:0] regOut3,
    output logic [1:0] selOut,
    output logic       wrStrobe,
    output logic       abortPulse
);

    localparam int unsigned  CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] IDLE_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {S_CMD, S_HI, S_LO, S_COMMIT} state_t;
    typedef enum logic [1:0] {OP_WRITE, OP_CLEAR, OP_INC, OP_SEL} op_t;

    state_t        r_state;
    state_t        w_next;
    op_t           r_op;
    logic [1:0]    r_addr;
    logic [7:0]    r_data;
    logic [7:0]    r_regs [4];
    logic [1:0]    r_sel;
    logic [CW-1:0] r_idle;
    logic          r_abort;

    logic          w_xfer;
    logic          w_wait;
    logic          w_abort;
    logic [7:0]    w_wval;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_CMD;
        else        r_state <= w_next;
    end

    // Next-state decode, transfer/abort qualification and state-decoded outputs
    always_comb begin
        w_next   = r_state;
        nibReady = (r_state != S_COMMIT);
        wrStrobe = (r_state == S_COMMIT);
        w_xfer   = nibValid && (r_state != S_COMMIT);
        w_wait   = ((r_state == S_HI) || (r_state == S_LO)) && !w_xfer;
        w_abort  = (TIMEOUT > 0) && w_wait && (r_idle == IDLE_LAST);
        case (r_state)
            S_CMD: begin
                if (w_xfer) begin
                    case (op_t'(nibIn[3:2]))
                        OP_WRITE:         w_next = S_HI;
                        OP_CLEAR, OP_INC: w_next = S_COMMIT;
                        default:          w_next = S_CMD;
                    endcase
                end
            end
            S_HI: begin
                if (w_xfer)       w_next = S_LO;
                else if (w_abort) w_next = S_CMD;
            end
            S_LO: begin
                if (w_xfer)       w_next = S_COMMIT;
                else if (w_abort) w_next = S_CMD;
            end
            S_COMMIT: w_next = S_CMD;
            default:  w_next = S_CMD;
        endcase
    end

    // Value written to reg[addr] in the COMMIT cycle
    always_comb begin
        w_wval = r_data;
        case (r_op)
            OP_WRITE: w_wval = r_data;
            OP_CLEAR: w_wval = '0;
            OP_INC:   w_wval = r_regs[r_addr] + 8'd1;
            default:  w_wval = r_data;
        endcase
    end

    // Command latches, data capture, idle counter, register bank and select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) r_regs[i] <= RESET_VAL;
            r_op    <= OP_WRITE;
            r_addr  <= '0;
            r_data  <= '0;
            r_sel   <= '0;
            r_idle  <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_abort;
            // The abort edge clears the counter, so it never has to saturate.
            if (w_wait && !w_abort) r_idle <= r_idle + CW'(1);
            else                    r_idle <= '0;
            case (r_state)
                S_CMD: begin
                    if (w_xfer) begin
                        r_op   <= op_t'(nibIn[3:2]);
                        r_addr <= nibIn[1:0];
                        if (op_t'(nibIn[3:2]) == OP_SEL) r_sel <= nibIn[1:0];
                    end
                end
                S_HI:     if (w_xfer) r_data[7:4] <= nibIn;
                S_LO:     if (w_xfer) r_data[3:0] <= nibIn;
                S_COMMIT: begin
                    r_regs[r_addr] <= w_wval;
                    r_sel          <= r_addr;
                end
                default: ;
            endcase
        end
    end

    assign regOut0    = r_regs[0];
    assign regOut1    = r_regs[1];
    assign regOut2    = r_regs[2];
    assign regOut3    = r_regs[3];
    assign selOut     = r_sel;
    assign abortPulse = r_abort;

endmodule

// File: tb/tb_reg_bank_loader.sv
// Self-checking bench for reg_bank_loader (TIMEOUT = 4, RESET_VAL = 8'h00).
module tb_reg_bank_loader;

    localparam int unsigned TO = 4;
    localparam logic [7:0]  RV = 8'h00;

    logic       clk;
    logic       rst_n;
    logic [3:0] nibIn;
    logic       nibValid;
    logic       nibReady;
    logic [7:0] regOut0, regOut1, regOut2, regOut3;
    logic [1:0] selOut;
    logic       wrStrobe;
    logic       abortPulse;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference: the architectural register file and the select
    logic [7:0] m_reg [4];
    logic [1:0] m_sel;

    typedef struct {
        logic [3:0] cmd;
        logic [7:0] data;
        logic [1:0] chk_addr;
        logic [7:0] exp_val;
        logic [1:0] exp_sel;
    } vec_t;
    vec_t vecs [12];

    reg_bank_loader #(.RESET_VAL(RV), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .nibIn(nibIn), .nibValid(nibValid),
        .nibReady(nibReady), .regOut0(regOut0), .regOut1(regOut1),
        .regOut2(regOut2), .regOut3(regOut3), .selOut(selOut),
        .wrStrobe(wrStrobe), .abortPulse(abortPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] get_reg(input int unsigned i);
        case (i)
            0: return regOut0;
            1: return regOut1;
            2: return regOut2;
            default: return regOut3;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = RV;
        m_sel = 2'd0;
    endtask

    task automatic chk_model(input string tag);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_reg%0d", tag, i), {24'd0, get_reg(i)}, {24'd0, m_reg[i]});
        chk($sformatf("%s_sel", tag), {30'd0, selOut}, {30'd0, m_sel});
    endtask

    // Present one nibble and hold it until it is accepted; returns 1 time unit after the accepting edge
    task automatic put(input logic [3:0] n);
        int unsigned k = 0;
        @(negedge clk);
        nibIn    = n;
        nibValid = 1'b1;
        while (!nibReady && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (!nibReady) chk("ready_wait", {31'd0, nibReady}, 32'd1);
        @(posedge clk);
        #1;
        nibValid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        nibValid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send one complete command with optional idle gaps inside a WRITE and update the reference
    task automatic do_cmd(input logic [3:0] cmd, input logic [7:0] data,
                          input int unsigned g1, input int unsigned g2);
        logic [1:0] op;
        logic [1:0] a;
        op = cmd[3:2];
        a  = cmd[1:0];
        put(cmd);
        if (op == 2'd3) begin
            chk("sel_nostrobe", {31'd0, wrStrobe}, 32'd0);
            m_sel = a;
            chk_model("sel");
            return;
        end
        if (op == 2'd0) begin
            idle(g1);
            if (g1 >= TO) begin
                chk("abort_hi", {31'd0, abortPulse}, 32'd1);
                idle(1);
                chk("abort_hi_end", {31'd0, abortPulse}, 32'd0);
                chk_model("abort_hi");
                return;
            end
            put(data[7:4]);
            idle(g2);
            if (g2 >= TO) begin
                chk("abort_lo", {31'd0, abortPulse}, 32'd1);
                idle(1);
                chk("abort_lo_end", {31'd0, abortPulse}, 32'd0);
                chk_model("abort_lo");
                return;
            end
            put(data[3:0]);
        end
        chk("commit_strobe", {31'd0, wrStrobe}, 32'd1);
        chk("commit_ready", {31'd0, nibReady}, 32'd0);
        chk("commit_noabort", {31'd0, abortPulse}, 32'd0);
        case (op)
            2'd0: m_reg[a] = data;
            2'd1: m_reg[a] = 8'h00;
            default: m_reg[a] = m_reg[a] + 8'd1;
        endcase
        m_sel = a;
        @(posedge clk);
        #1;
        chk("post_commit_strobe", {31'd0, wrStrobe}, 32'd0);
        chk_model("cmd");
    endtask

    initial begin
        vecs[0]  = '{4'h2, 8'hA5, 2'd2, 8'hA5, 2'd2};
        vecs[1]  = '{4'h1, 8'hFF, 2'd1, 8'hFF, 2'd1};
        vecs[2]  = '{4'h9, 8'h00, 2'd1, 8'h00, 2'd1};
        vecs[3]  = '{4'h1, 8'h3C, 2'd1, 8'h3C, 2'd1};
        vecs[4]  = '{4'h5, 8'h00, 2'd1, 8'h00, 2'd1};
        vecs[5]  = '{4'hF, 8'h00, 2'd2, 8'hA5, 2'd3};
        vecs[6]  = '{4'hA, 8'h00, 2'd2, 8'hA6, 2'd2};
        vecs[7]  = '{4'h3, 8'h80, 2'd3, 8'h80, 2'd3};
        vecs[8]  = '{4'hB, 8'h00, 2'd3, 8'h81, 2'd3};
        vecs[9]  = '{4'h0, 8'h7E, 2'd0, 8'h7E, 2'd0};
        vecs[10] = '{4'hD, 8'h00, 2'd0, 8'h7E, 2'd1};
        vecs[11] = '{4'h6, 8'h00, 2'd2, 8'h00, 2'd2};

        rst_n    = 1'b0;
        nibIn    = 4'h0;
        nibValid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, nibReady}, 32'd1);
        chk("rst_strobe", {31'd0, wrStrobe}, 32'd0);
        chk("rst_abort", {31'd0, abortPulse}, 32'd0);
        chk_model("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed command table, expected values worked out by hand
        foreach (vecs[i]) begin
            do_cmd(vecs[i].cmd, vecs[i].data, 0, 0);
            chk($sformatf("vec%0d_reg", i), {24'd0, get_reg(vecs[i].chk_addr)}, {24'd0, vecs[i].exp_val});
            chk($sformatf("vec%0d_sel", i), {30'd0, selOut}, {30'd0, vecs[i].exp_sel});
        end

        // Asynchronous reset asserted inside a COMMIT cycle, checked before any clock edge
        put(4'h9);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_strobe", {31'd0, wrStrobe}, 32'd0);
        chk("arst_ready", {31'd0, nibReady}, 32'd1);
        chk_model("arst");
        @(negedge clk);
        rst_n = 1'b1;

        // Timeout after four idle cycles in LO
        put(4'h0);
        put(4'h7);
        idle(3);
        chk("to_before", {31'd0, abortPulse}, 32'd0);
        idle(1);
        chk("to_pulse", {31'd0, abortPulse}, 32'd1);
        idle(1);
        chk("to_pulse_end", {31'd0, abortPulse}, 32'd0);
        chk("to_reg0", {24'd0, regOut0}, {24'd0, RV});
        do_cmd(4'hE, 8'h00, 0, 0);
        chk("to_next_sel", {30'd0, selOut}, 32'd2);

        // Three idle cycles in HI and LO stay just below the abort threshold
        do_cmd(4'h0, 8'h5A, 3, 3);
        chk("near_to_reg0", {24'd0, regOut0}, 32'h5A);

        // Reset in the middle of a WRITE discards it
        put(4'h1);
        put(4'hB);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_model("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(4'h0, 8'hC3, 0, 0);
        chk("mid_rst_reg0", {24'd0, regOut0}, 32'hC3);
        chk("mid_rst_reg1", {24'd0, regOut1}, {24'd0, RV});

        // Next nibble held valid through COMMIT is consumed exactly once
        put(4'h1);
        put(4'h2);
        put(4'h3);
        put(4'h9);
        @(posedge clk);
        #1;
        idle(3);
        chk("hold_reg1", {24'd0, regOut1}, 32'h24);
        m_reg[1] = 8'h24;
        m_sel    = 2'd1;
        chk_model("hold");

        // Random command stream against the reference
        for (int i = 0; i < 150; i++) begin
            logic [3:0] c;
            logic [7:0] d;
            int unsigned g1, g2;
            c  = 4'($urandom_range(0, 15));
            d  = 8'($urandom);
            g1 = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
            g2 = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
            do_cmd(c, d, g1, g2);
            idle($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
